exc_ctrl: RTL and testbench

Exception controller in the MEM stage, directly upstream of the CP0 register file. Each cycle it takes the exception flags, PC and delay-slot bit of the instruction in MEM. It forwards in-flight WB-stage CP0 writes over the CP0 status/cause/epc values, evaluates pending interrupts, and drives the exception-type code, instruction address and delay-slot bit into CP0. It also runs a flush sequencer that steers the PC to the exception vector or to EPC on ERET.

---
 rtl/exc_ctrl.sv | 152 +++++++++++++++
 tb/tb_exc_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: forwards WB CP0 writes, prioritises exceptions,
// and sequences the pipeline flush. Optional macro EXC_INT_SYNC_EN adds a 2-flop int_i synchronizer.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        mem_syscall_i,
  input  logic        mem_ri_i,
  input  logic        mem_ov_i,
  input  logic        mem_trap_i,
  input  logic        mem_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] inst_addr_o,
  output logic        in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [4:0]  ADDR_STATUS = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
  localparam logic [4:0]  ADDR_EPC    = 5'd14;
  localparam logic [31:0] CODE_INT  = 32'h0000_0001;
  localparam logic [31:0] CODE_RI   = 32'h0000_000a;
  localparam logic [31:0] CODE_OV   = 32'h0000_000c;
  localparam logic [31:0] CODE_TRAP = 32'h0000_000d;
  localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
  localparam logic [31:0] CODE_ERET = 32'h0000_000e;

  typedef enum logic [0:0] {IDLE, FLUSH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       target_q;
  logic [5:0]        int_s;
  logic [31:0]       status_eff;
  logic [31:0]       cause_eff;
  logic [31:0]       epc_eff;
  logic              int_pend;
  logic [31:0]       exc_code;
  logic              unused_bits;

`ifdef EXC_INT_SYNC_EN
  logic [5:0] int_meta;
  logic [5:0] int_sync;

  // Two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= 6'd0;
      int_sync <= 6'd0;
    end else begin
      int_meta <= int_i;
      int_sync <= int_meta;
    end
  end
  assign int_s = int_sync;
`else
  assign int_s = int_i;
`endif

  // Zero-cycle forwarding of the WB-stage CP0 write
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS) status_eff = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC)    epc_eff    = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE) begin
      cause_eff[23:22] = wb_cp0_data_i[23:22];
      cause_eff[9:8]   = wb_cp0_data_i[9:8];
    end
  end

  assign int_pend = status_eff[0] & ~status_eff[1] &
                    (|({int_s, cause_eff[9:8]} & status_eff[15:8]));

  assign unused_bits = &{1'b0, status_eff[31:16], status_eff[7:2],
                         cause_eff[31:10], cause_eff[7:0]};

  // Priority encoder; only a valid instruction in IDLE can raise an event
  always_comb begin
    exc_code = 32'd0;
    if (mem_valid_i && state == IDLE) begin
      if (int_pend)           exc_code = CODE_INT;
      else if (mem_ri_i)      exc_code = CODE_RI;
      else if (mem_ov_i)      exc_code = CODE_OV;
      else if (mem_trap_i)    exc_code = CODE_TRAP;
      else if (mem_syscall_i) exc_code = CODE_SYS;
      else if (mem_eret_i)    exc_code = CODE_ERET;
    end
  end

  always_comb begin
    excepttype_o   = 32'd0;
    inst_addr_o    = 32'd0;
    in_delayslot_o = 1'b0;
    flush_o        = 1'b0;
    new_pc_o       = 32'd0;
    if (!rst) begin
      excepttype_o   = exc_code;
      inst_addr_o    = mem_pc_i;
      in_delayslot_o = mem_in_delayslot_i;
      if (state == FLUSH) begin
        flush_o  = 1'b1;
        new_pc_o = target_q;
      end else if (exc_code != 32'd0) begin
        flush_o  = 1'b1;
        new_pc_o = (exc_code == CODE_ERET) ? epc_eff : EXC_VECTOR;
      end
    end
  end

  // Flush sequencer: holds flush_o and the captured target for FLUSH_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= CNT_W'(0);
      target_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_code != 32'd0) begin
            target_q <= new_pc_o;
            if (FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: the driver queues expected outputs per cycle, a monitor compares at negedge.
module tb_exc_ctrl;

`ifdef EXC_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  int_i = 6'd0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_pc_i = 32'd0;
  logic        mem_in_delayslot_i = 1'b0;
  logic        mem_syscall_i = 1'b0, mem_ri_i = 1'b0, mem_ov_i = 1'b0;
  logic        mem_trap_i = 1'b0, mem_eret_i = 1'b0;
  logic [31:0] cp0_status_i = 32'h1000_0000;
  logic [31:0] cp0_cause_i = 32'd0;
  logic [31:0] cp0_epc_i = 32'd0;
  logic        wb_cp0_we_i = 1'b0;
  logic [4:0]  wb_cp0_waddr_i = 5'd0;
  logic [31:0] wb_cp0_data_i = 32'd0;
  logic [31:0] excepttype_o, inst_addr_o, new_pc_o;
  logic        in_delayslot_o, flush_o;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_syscall_i(mem_syscall_i), .mem_ri_i(mem_ri_i), .mem_ov_i(mem_ov_i),
    .mem_trap_i(mem_trap_i), .mem_eret_i(mem_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .inst_addr_o(inst_addr_o), .in_delayslot_o(in_delayslot_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] et;
    logic [31:0] ia;
    logic        ds;
    logic        fl;
    logic [31:0] np;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;
  obs_t  got;

  always_comb got = {excepttype_o, inst_addr_o, in_delayslot_o, flush_o, new_pc_o};

  // Monitor: one queued expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    obs_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got et=%h ia=%h ds=%b fl=%b np=%h, want et=%h ia=%h ds=%b fl=%b np=%h",
                 t, got.et, got.ia, got.ds, got.fl, got.np, e.et, e.ia, e.ds, e.fl, e.np);
      end
    end
  end

  task automatic cyc(input string tag, input logic [31:0] et, input logic fl, input logic [31:0] np);
    obs_t e;
    e.et = et;
    e.ia = rst ? 32'd0 : mem_pc_i;
    e.ds = rst ? 1'b0 : mem_in_delayslot_i;
    e.fl = fl;
    e.np = np;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Flag order: {ri, ov, trap, syscall, eret}
  task automatic set_flags(input logic [4:0] f);
    {mem_ri_i, mem_ov_i, mem_trap_i, mem_syscall_i, mem_eret_i} = f;
  endtask

  // One accepted event: event cycle, one FLUSH cycle, then a bubble
  task automatic ev(input string tag, input logic [4:0] f, input logic [31:0] pc,
                    input logic [31:0] et, input logic [31:0] np);
    mem_valid_i = 1'b1;
    mem_pc_i = pc;
    set_flags(f);
    cyc(tag, et, 1'b1, np);
    set_flags(5'b0);
    wb_cp0_we_i = 1'b0;
    cyc({tag, "_flush"}, 32'd0, 1'b1, np);
    mem_valid_i = 1'b0;
    cyc({tag, "_idle"}, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic bubbles(input string tag, input int n);
    mem_valid_i = 1'b0;
    for (int i = 0; i < n; i++) cyc(tag, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset forces outputs to zero even with an event presented
    mem_valid_i = 1'b1; mem_pc_i = 32'h100; mem_syscall_i = 1'b1; mem_in_delayslot_i = 1'b1;
    cyc("reset0", 32'd0, 1'b0, 32'd0);
    cyc("reset1", 32'd0, 1'b0, 32'd0);
    rst = 1'b0;
    set_flags(5'b0);
    mem_in_delayslot_i = 1'b0;
    bubbles("post_reset", SYNC_LAT + 1);

    ev("syscall", 5'b00010, 32'h100, 32'h8, 32'h20);

    cp0_epc_i = 32'h200;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h400;
    ev("eret_fwd", 5'b00001, 32'h180, 32'he, 32'h400);
    ev("eret_plain", 5'b00001, 32'h184, 32'he, 32'h200);

    mem_in_delayslot_i = 1'b1;
    ev("ri_ov_sys", 5'b11010, 32'h84, 32'ha, 32'h20);
    mem_in_delayslot_i = 1'b0;
    ev("ov_trap", 5'b01100, 32'h88, 32'hc, 32'h20);
    ev("trap_sys", 5'b00110, 32'h8c, 32'hd, 32'h20);
    ev("sys_eret", 5'b00011, 32'h90, 32'h8, 32'h20);

    // Interrupt held pending across bubbles, beats syscall on the next valid instruction
    cp0_status_i = 32'h0000_0401;
    int_i = 6'b000001;
    mem_pc_i = 32'h300;
    bubbles("int_bubble", SYNC_LAT + 1);
    ev("int_valid", 5'b00010, 32'h300, 32'h1, 32'h20);
    int_i = 6'd0;
    bubbles("int_drain", SYNC_LAT + 1);

    // Synchronizer latency on first detection
    int_i = 6'b000001;
    mem_valid_i = 1'b1; mem_pc_i = 32'h600;
    for (int i = 0; i < SYNC_LAT; i++) cyc("int_lat", 32'd0, 1'b0, 32'd0);
    ev("int_first", 5'b0, 32'h600, 32'h1, 32'h20);
    int_i = 6'd0;
    bubbles("int_drain2", SYNC_LAT + 1);

    // EXL masks; forwarded status write unmasks in the same cycle
    cp0_status_i = 32'h0000_0403;
    int_i = 6'b000001;
    bubbles("mask_wait", SYNC_LAT);
    mem_valid_i = 1'b1; mem_pc_i = 32'h500;
    cyc("exl_masked", 32'd0, 1'b0, 32'd0);
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_0401;
    ev("status_fwd", 5'b0, 32'h500, 32'h1, 32'h20);
    int_i = 6'd0;
    bubbles("int_drain3", SYNC_LAT + 1);

    // Software interrupt via forwarded cause[8]; cause[10] is not forwarded
    cp0_status_i = 32'h0000_0401;
    mem_valid_i = 1'b1; mem_pc_i = 32'h510;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0400;
    cyc("cause_bit10", 32'd0, 1'b0, 32'd0);
    cp0_status_i = 32'h0000_0101;
    wb_cp0_data_i = 32'h0000_0100;
    ev("cause_fwd", 5'b0, 32'h510, 32'h1, 32'h20);
    cp0_status_i = 32'h1000_0000;

    // Second event during FLUSH is ignored
    mem_valid_i = 1'b1; mem_pc_i = 32'h700;
    set_flags(5'b00010);
    cyc("sys_a", 32'h8, 1'b1, 32'h20);
    set_flags(5'b01000); mem_pc_i = 32'h704;
    cyc("ov_ignored", 32'd0, 1'b1, 32'h20);
    set_flags(5'b0); mem_valid_i = 1'b0;
    cyc("ov_after", 32'd0, 1'b0, 32'd0);

    // Reset mid-FLUSH
    mem_valid_i = 1'b1; mem_pc_i = 32'h800;
    set_flags(5'b00010);
    cyc("sys_b", 32'h8, 1'b1, 32'h20);
    set_flags(5'b0); rst = 1'b1;
    cyc("rst_mid_flush", 32'd0, 1'b0, 32'd0);
    rst = 1'b0;
    cyc("idle_after_rst", 32'd0, 1'b0, 32'd0);
    ev("sys_after_rst", 5'b00010, 32'h804, 32'h8, 32'h20);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
